// File: rtl/bcd_pkg.sv
// Shared widths, 7-segment glyph constants and segment bit positions for the
// BCD display decoder. Glyphs are active-high, packed as {a,b,c,d,e,f,g}.
package bcd_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational digit-to-segment lookup. Define HEX_DIGITS_EN to show glyphs
// A-F for codes 10-15; otherwise those codes blank the display.
module bcd_seg_lut
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  output logic [SEG_W-1:0] seg,
  output logic             invalid
);

  // Digit decode; the default arm also catches unknown inputs so nothing latches
  always_comb begin
    seg     = SEG_BLANK;
    invalid = 1'b1;
    case (bcd_in)
      4'd0:  begin seg = SEG_0; invalid = 1'b0; end
      4'd1:  begin seg = SEG_1; invalid = 1'b0; end
      4'd2:  begin seg = SEG_2; invalid = 1'b0; end
      4'd3:  begin seg = SEG_3; invalid = 1'b0; end
      4'd4:  begin seg = SEG_4; invalid = 1'b0; end
      4'd5:  begin seg = SEG_5; invalid = 1'b0; end
      4'd6:  begin seg = SEG_6; invalid = 1'b0; end
      4'd7:  begin seg = SEG_7; invalid = 1'b0; end
      4'd8:  begin seg = SEG_8; invalid = 1'b0; end
      4'd9:  begin seg = SEG_9; invalid = 1'b0; end
`ifdef HEX_DIGITS_EN
      4'd10: begin seg = SEG_A; invalid = 1'b1; end
      4'd11: begin seg = SEG_B; invalid = 1'b1; end
      4'd12: begin seg = SEG_C; invalid = 1'b1; end
      4'd13: begin seg = SEG_D; invalid = 1'b1; end
      4'd14: begin seg = SEG_E; invalid = 1'b1; end
      4'd15: begin seg = SEG_F; invalid = 1'b1; end
`else
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
        seg     = SEG_BLANK;
        invalid = 1'b1;
      end
`endif
      default: begin
        seg     = SEG_BLANK;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd.sv
// BCD to 7-segment decoder top: combinational decode plus a registered copy
// for glitch-free display pins. HEX_DIGITS_EN selects hex glyphs in the LUT.
module bcd
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [SEG_W-1:0] seg,
  input  logic [BCD_W-1:0] bcd_in,
  output logic             invalid,
  output logic [SEG_W-1:0] seg_q,
  output logic             invalid_q
);

  logic [SEG_W-1:0] seg_s;
  logic             invalid_s;
  logic [SEG_W-1:0] seg_r;
  logic             invalid_r;

  bcd_seg_lut u_lut (
    .bcd_in  (bcd_in),
    .seg     (seg_s),
    .invalid (invalid_s)
  );

  // Display register stage: loads every edge, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r     <= SEG_BLANK;
      invalid_r <= 1'b0;
    end else begin
      seg_r     <= seg_s;
      invalid_r <= invalid_s;
    end
  end

  assign seg       = seg_s;
  assign invalid   = invalid_s;
  assign seg_q     = seg_r;
  assign invalid_q = invalid_r;

endmodule

// File: tb/tb_bcd.sv
// Scoreboard bench for bcd: expected registered outputs are queued at stimulus
// time and checked by an independent monitor one edge later.
module tb_bcd;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] bcd_in;
  logic       invalid;
  logic [6:0] seg_q;
  logic       invalid_q;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_q;

  bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .bcd_in    (bcd_in),
    .invalid   (invalid),
    .seg_q     (seg_q),
    .invalid_q (invalid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which segment letters are lit for each code
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                      "acdefg", "abc", "abcdefg", "abcdfg",
                      "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] model(input int d);
    logic [6:0] s;
    string      l;
    s = 7'b0;
    l = lit[d];
`ifndef HEX_DIGITS_EN
    if (d > 9) l = "";
`endif
    for (int k = 0; k < l.len(); k++) s[6 - (l[k] - "a")] = 1'b1;
    return {(d > 9) ? 1'b1 : 1'b0, s};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply a digit mid-cycle, check the combinational path and that the register has not moved
  task automatic drive(input int d);
    logic [7:0] m;
    m = model(d);
    bcd_in = d[3:0];
    #1;
    chk($sformatf("comb_%0d", d), {invalid, seg}, m);
    chk($sformatf("hold_before_edge_%0d", d), {invalid_q, seg_q}, last_q);
    exp_q.push_back(m);
    last_q = m;
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_out", {invalid_q, seg_q}, e);
      end
    end
  end

  initial begin : stim
    rst_n  = 1'b0;
    bcd_in = 4'd0;
    last_q = 8'b0;
    #1;
    chk("reset_regs", {invalid_q, seg_q}, 8'b0);
    chk("comb_in_reset", {invalid, seg}, 8'b0111_1110);

    // Release with digit 4: register must wait for the first edge
    @(negedge clk);
    rst_n = 1'b1;
    drive(4);

    for (int d = 0; d < 16; d++) begin
      @(negedge clk);
      drive(d);
    end

    @(negedge clk); drive(3);
    @(negedge clk); drive(11);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-run with digit 8 showing
    @(negedge clk); drive(8);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_clear", {invalid_q, seg_q}, 8'b0);
    chk("comb_during_reset", {invalid, seg}, 8'b0111_1111);
    last_q = 8'b0;
    @(posedge clk); #1;
    chk("held_in_reset", {invalid_q, seg_q}, 8'b0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
